// File: rtl/riscv_i32_dmem_sequencer.sv
// Data-memory sequencer: splits misaligned loads/stores into two word accesses.
// Split support is enabled by defining RISCV_I32_DMEM_SEQUENCER_SPLIT_EN.
module riscv_i32_dmem_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_address,
    input  logic [31:0] req_write_data,
    output logic        req_ready,
    output logic        mem_valid,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_write_data,
    input  logic        mem_ack,
    input  logic [31:0] mem_read_data,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_error
);

`ifdef RISCV_I32_DMEM_SEQUENCER_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        FIRST,
        SECOND,
        RESP
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic [7:0]  mask_q;
    logic [3:0]  base;
    logic [7:0]  mask_req;
    logic        split;
    logic        reject;
    logic [31:0] word_addr;
    logic        accept;

    assign accept    = req_valid && (state == IDLE);
    assign split     = |mask_q[7:4];
    assign reject    = split && !SplitEn;
    assign word_addr = {addr_q[31:2], 2'b00};

    // Lane mask of the incoming request, 8 lanes wide so a split shows up in [7:4]
    always_comb begin
        unique case (req_size)
            2'd0:    base = 4'b0001;
            2'd1:    base = 4'b0011;
            default: base = 4'b1111;
        endcase
        mask_req = {4'b0000, base} << req_address[1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and output decode; all outputs come from latched request state
    always_comb begin
        state_next      = state;
        req_ready       = 1'b0;
        mem_valid       = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 32'd0;
        mem_byte_enable = 4'd0;
        mem_write_data  = 32'd0;
        resp_valid      = 1'b0;
        resp_data       = 32'd0;
        resp_error      = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = FIRST;
                end
            end
            FIRST: begin
                if (reject) begin
                    state_next = RESP;
                end else begin
                    mem_valid       = 1'b1;
                    mem_write       = write_q;
                    mem_address     = word_addr;
                    mem_byte_enable = mask_q[3:0];
                    mem_write_data  = wdata_q;
                    if (mem_ack) begin
                        state_next = split ? SECOND : RESP;
                    end
                end
            end
            SECOND: begin
                mem_valid       = 1'b1;
                mem_write       = write_q;
                mem_address     = word_addr + 32'd4;
                mem_byte_enable = mask_q[7:4];
                mem_write_data  = wdata_q;
                if (mem_ack) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_data  = rdata_q;
                resp_error = reject;
                state_next = IDLE;
            end
        endcase
    end

    // Request latch and per-lane merge of load data on each acknowledged access
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            mask_q  <= 8'd0;
            rdata_q <= 32'd0;
        end else if (accept) begin
            write_q <= req_write;
            addr_q  <= req_address;
            wdata_q <= req_write_data;
            mask_q  <= mask_req;
            rdata_q <= 32'd0;
        end else if (mem_valid && mem_ack && !write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_byte_enable[i]) begin
                    rdata_q[8*i +: 8] <= mem_read_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_riscv_i32_dmem_sequencer.sv
// Self-checking bench for riscv_i32_dmem_sequencer.
// Expected accesses are derived byte-by-byte from the request address and size.
module tb_riscv_i32_dmem_sequencer;

`ifdef RISCV_I32_DMEM_SEQUENCER_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_address;
    logic [31:0] req_write_data;
    logic        req_ready;
    logic        mem_valid;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_write_data;
    logic        mem_ack;
    logic [31:0] mem_read_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        resp_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    riscv_i32_dmem_sequencer dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_write      (req_write),
        .req_size       (req_size),
        .req_address    (req_address),
        .req_write_data (req_write_data),
        .req_ready      (req_ready),
        .mem_valid      (mem_valid),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_byte_enable(mem_byte_enable),
        .mem_write_data (mem_write_data),
        .mem_ack        (mem_ack),
        .mem_read_data  (mem_read_data),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_error     (resp_error)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic scramble_req();
        req_write      = 1'($urandom);
        req_size       = 2'($urandom);
        req_address    = $urandom;
        req_write_data = $urandom;
    endtask

    task automatic accept_req(input logic wr, input logic [1:0] size,
                              input logic [31:0] addr,
                              input logic [31:0] wdata);
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        chk("idle_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        req_valid      = 1'b1;
        req_write      = wr;
        req_size       = size;
        req_address    = addr;
        req_write_data = wdata;
        @(negedge clk);
        req_valid = 1'b0;
        scramble_req();
        chk("busy_ready", {31'd0, req_ready}, 32'd0);
    endtask

    // One full transaction with the memory responding after w0/w1 wait cycles
    task automatic run_txn(input logic wr, input logic [1:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input int w0, input int w1,
                           input logic [31:0] rd0, input logic [31:0] rd1);
        int          n;
        int          nacc;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] b;
        logic [31:0] exp_data;
        logic        exp_err;
        int          waits;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] rd;

        n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        a0  = addr & 32'hFFFF_FFFC;
        a1  = a0 + 32'd4;
        be0 = 4'd0;
        be1 = 4'd0;
        for (int k = 0; k < n; k++) begin
            b = addr + 32'(k);
            if ((b & 32'hFFFF_FFFC) == a0) be0[b[1:0]] = 1'b1;
            else                           be1[b[1:0]] = 1'b1;
        end
        exp_err  = (be1 != 4'd0) && !SplitEn;
        nacc     = (be1 == 4'd0) ? 1 : (SplitEn ? 2 : 0);
        exp_data = 32'd0;
        if (!wr && !exp_err) begin
            for (int l = 0; l < 4; l++) begin
                if (be0[l]) exp_data[8*l +: 8] = rd0[8*l +: 8];
                if (be1[l]) exp_data[8*l +: 8] = rd1[8*l +: 8];
            end
        end

        accept_req(wr, size, addr, wdata);

        if (nacc == 0) begin
            chk("reject_no_access", {31'd0, mem_valid}, 32'd0);
            mem_ack       = 1'b1;
            mem_read_data = $urandom;
            @(negedge clk);
            mem_ack = 1'b0;
        end
        for (int k = 0; k < nacc; k++) begin
            waits = (k == 0) ? w0 : w1;
            a     = (k == 0) ? a0 : a1;
            be    = (k == 0) ? be0 : be1;
            rd    = (k == 0) ? rd0 : rd1;
            for (int w = 0; w <= waits; w++) begin
                chk("mem_valid", {31'd0, mem_valid}, 32'd1);
                chk("mem_address", mem_address, a);
                chk("mem_byte_enable", {28'd0, mem_byte_enable}, {28'd0, be});
                chk("mem_write", {31'd0, mem_write}, {31'd0, wr});
                chk("mem_write_data", mem_write_data, wdata);
                chk("early_resp", {31'd0, resp_valid}, 32'd0);
                mem_ack       = (w == waits);
                mem_read_data = (w == waits) ? rd : $urandom;
                @(negedge clk);
            end
            mem_ack = 1'b0;
        end

        chk("resp_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("resp_data", resp_data, exp_data);
        chk("resp_error", {31'd0, resp_error}, {31'd0, exp_err});
        chk("resp_ready", {31'd0, req_ready}, 32'd0);
        mem_ack       = 1'($urandom);
        mem_read_data = $urandom;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    endtask

    // Reset asserted while an access is outstanding, with mem_ack high
    task automatic reset_mid(input logic [31:0] addr, input bit second);
        accept_req(1'b0, 2'd2, addr, 32'd0);
        if (second) begin
            mem_ack       = 1'b1;
            mem_read_data = $urandom;
            @(negedge clk);
            mem_ack = 1'b0;
            chk("rst_second_addr", mem_address, (addr & 32'hFFFF_FFFC) + 32'd4);
        end
        chk("rst_pre_valid", {31'd0, mem_valid}, 32'd1);
        reset_n       = 1'b0;
        mem_ack       = 1'b1;
        mem_read_data = $urandom;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk("rst_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("rst_idle_valid", {31'd0, mem_valid}, 32'd0);
    endtask

    initial begin
        reset_n        = 1'b0;
        req_valid      = 1'b0;
        req_write      = 1'b0;
        req_size       = 2'd0;
        req_address    = 32'd0;
        req_write_data = 32'd0;
        mem_ack        = 1'b1;
        mem_read_data  = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        chk("reset_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("reset_mem_write", {31'd0, mem_write}, 32'd0);
        chk("reset_mem_address", mem_address, 32'd0);
        chk("reset_be", {28'd0, mem_byte_enable}, 32'd0);
        chk("reset_wdata", mem_write_data, 32'd0);
        chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset_resp_data", resp_data, 32'd0);
        chk("reset_resp_error", {31'd0, resp_error}, 32'd0);
        reset_n = 1'b1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("post_reset_resp", {31'd0, resp_valid}, 32'd0);

        run_txn(1'b0, 2'd2, 32'h0000_1000, 32'd0, 2, 0,
                32'hAABB_CCDD, 32'd0);
        run_txn(1'b0, 2'd2, 32'h0000_1003, 32'd0, 1, 2,
                32'h1122_3344, 32'h5566_7788);
        run_txn(1'b1, 2'd1, 32'h0000_2003, 32'hCAFE_BABE, 0, 0,
                32'd0, 32'd0);
        run_txn(1'b1, 2'd0, 32'h0000_3002, 32'h1234_5678, 5, 0,
                32'd0, 32'd0);
        run_txn(1'b0, 2'd2, 32'hFFFF_FFFE, 32'd0, 0, 1,
                32'h0102_0304, 32'hA1A2_A3A4);
        run_txn(1'b0, 2'd3, 32'h0000_4000, 32'd0, 0, 0,
                32'h9988_7766, 32'd0);
        run_txn(1'b0, 2'd1, 32'h0000_5002, 32'd0, 1, 0,
                32'hF0E1_D2C3, 32'd0);
        run_txn(1'b0, 2'd0, 32'h0000_6001, 32'd0, 0, 0,
                32'h4433_2211, 32'd0);

        reset_mid(32'h0000_7000, 1'b0);
        if (SplitEn) reset_mid(32'h0000_7002, 1'b1);

        for (int t = 0; t < 60; t++) begin
            run_txn(1'($urandom), 2'($urandom), $urandom, $urandom,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
